multiport_reg_file: RTL
=======================

// Module: multiport_reg_file
// PURPOSE
//  Parametrised multi-port integer register file for the pipelined core (decode reads, writeback writes).
//  Provides NRD combinational read ports and NWR write ports with optional same-cycle write-to-read bypass.
//  Adds a per-register busy scoreboard: issue marks the destination pending, writeback clears it.
//  Decode uses this scoreboard to raise RAW stalls.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREGS     32  number of registers; AW = $clog2(NREGS)
//  NRD       2   read ports
//  NWR       2   write ports; higher port index has priority
//  ZERO_REG  1   1: register 0 is hardwired to zero and never busy
//  BYPASS    1   1: a same-cycle write is forwarded to matching read ports
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high reset
//  rd_addr     in   NRD*AW     read addresses, port i = [i*AW +: AW]
//  rd_data     out  NRD*XLEN   read data, port i = [i*XLEN +: XLEN]
//  rd_busy     out  NRD        1 = register at rd_addr[i] has a pending producer
//  wr_en       in   NWR        write enables
//  wr_addr     in   NWR*AW     write addresses
//  wr_data     in   NWR*XLEN   write data
//  issue_en    in   1          mark issue_addr busy (instruction with destination issued)
//  issue_addr  in   AW         destination being issued
//  flush       in   1          synchronous clear of all busy bits (pipeline flush)
// BEHAVIOUR
//  Reset (async, while high): all registers = 0 and all busy bits = 0.
//   - Writes, issues and flush are ignored during reset.
//   - Bypass is gated off, so rd_data = 0 and rd_busy = 0 on every port.
//  Write (posedge clk, reset low):
//   - For each port p with wr_en[p], regs[wr_addr[p]] <= wr_data[p].
//   - Same address on several ports: highest p wins.
//   - With ZERO_REG=1, writes to address 0 are dropped.
//   - Addresses >= NREGS are dropped.
//  Read (combinational, 0-cycle latency), per port i, with a = rd_addr[i]:
//   1. ZERO_REG && a == 0 -> 0.
//   2. Else BYPASS && some wr_en[p] && wr_addr[p] == a -> wr_data of the highest such p.
//   3. Else regs[a].
//   - a >= NREGS -> 0.
//  Scoreboard busy[NREGS] (posedge clk, reset low), priority high to low:
//   1. flush: all busy <= 0. A same-cycle issue_en is ignored; writes still commit.
//   2. issue_en: busy[issue_addr] <= 1. This wins over a same-cycle write clearing the same register, because the new producer supersedes it.
//   3. Any enabled write port to r: busy[r] <= 0.
//   - Issue to register 0 with ZERO_REG=1 is ignored.
//  rd_busy[i] = busy[a] & ~(BYPASS & any wr_en[p] with wr_addr[p] == a).
//   - Forced 0 for register 0 when ZERO_REG=1.
//   - With BYPASS=0, rd_busy[i] = busy[a] (consumer waits one more cycle).
//  Write to a non-busy register is legal; busy stays 0.
//  No backpressure: all inputs are accepted every cycle.
//  Mid-operation reset clears state immediately, without waiting for a clock edge.
// TESTING
//  T1 reset: assert reset with regs preloaded and busy set -> all rd_data = 0 and rd_busy = 0 within the same cycle.
//  T2 bypass: wr_en[0]=1, wr_addr[0]=5, wr_data[0]=0xDEADBEEF, rd_addr[1]=5 in the same cycle
//     -> rd_data[1] = 0xDEADBEEF combinationally; next cycle with no write it still reads 0xDEADBEEF.
//  T3 port priority: wr0 (7, 0x11) and wr1 (7, 0x22) in the same cycle
//     -> bypass read of 7 returns 0x22; next cycle regs[7] = 0x22.
//  T4 zero reg: write 0xFFFF_FFFF to x0 and issue x0 -> reading x0 returns 0 and rd_busy = 0.
//  T5 scoreboard:
//     - issue x3 -> rd_busy = 1 on the following cycles.
//     - Write x3 -> rd_busy = 0 in the write cycle (BYPASS=1).
//     - Same-cycle issue and write to x3 -> busy remains 1.
//  T6 flush: busy x3, x9 set; flush together with issue x4 -> next cycle all rd_busy = 0 and x4 is not busy.
//     Re-run T2-T5 with NRD=3, NWR=1, BYPASS=0.

Source files
------------

// File: rtl/multiport_reg_file.sv
// Multi-port integer register file with combinational reads, optional write-to-read
// bypass, and a per-register busy scoreboard used by decode for RAW stall detection.
module multiport_reg_file #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  input  logic                flush
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  // True for an address that names a real, writable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && addr_ok(wr_addr[p*AW +: AW])) begin
        regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
        busy_d[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    // A new producer supersedes a same-cycle writeback; flush overrides both.
    if (flush) begin
      busy_d = '0;
    end else if (issue_en && addr_ok(issue_addr)) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] fwd;

    assign a = rd_addr[i*AW +: AW];

    // Ascending scan so the highest matching write port is the one forwarded.
    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int p = 0; p < NWR; p++) begin
        if ((BYPASS != 0) && !reset && wr_en[p] && (wr_addr[p*AW +: AW] == a)) begin
          hit = 1'b1;
          fwd = wr_data[p*XLEN +: XLEN];
        end
      end
    end

    assign rd_data[i*XLEN +: XLEN] = !addr_ok(a) ? '0 : (hit ? fwd : regs_q[a]);
    assign rd_busy[i]              = addr_ok(a) && busy_q[a] && !hit;
  end

endmodule
